// File: rtl/board_io_pkg.sv
// Shared definitions for the board I/O shift-register drivers (74HC595 writer, 74HC165 reader).
// Holds the frame-sequencer state encoding and the default chain geometry.
package board_io_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_HIGH   = 3'd3,
      ST_LOW    = 3'd4,
      ST_DONE   = 3'd5
   } shift_state_t;

   localparam int DEFAULT_WIDTH   = 16;
   localparam int DEFAULT_CLK_DIV = 4;

endpackage

// File: rtl/control_74hc165_reader.sv
// Reads a chain of 74HC165 PISO registers: pulses PL, clocks CP and deserialises QH MSB-first.
// Every output is a register; data_out changes only in the DONE cycle alongside data_valid.
module control_74hc165_reader
   import board_io_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic             s_clk,
   input  logic             s_reset,
   input  logic             start,
   input  logic             data_in,
   output logic             load_n,
   output logic             data_clock,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             busy
);

   // A one-cycle phase still needs a 1-bit counter to keep the compare well formed.
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(WIDTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   shift_state_t     state_reg;
   logic [DIV_W-1:0] div_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] shreg;
   logic             phase_end;

   assign phase_end = (div_cnt == DIV_LAST);

   always_ff @(posedge s_clk) begin
      if (s_reset) begin
         state_reg  <= ST_IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         load_n     <= 1'b1;
         data_clock <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_valid <= 1'b0;

         // Every timed state leaves on phase_end, so wrapping here restarts the next phase at 0.
         if (state_reg == ST_IDLE || state_reg == ST_DONE || phase_end)
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + 1'b1;

         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_reg <= ST_LOAD;
                  busy      <= 1'b1;
                  load_n    <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (phase_end) begin
                  state_reg <= ST_SETTLE;
                  load_n    <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (phase_end) begin
                  shreg      <= {shreg[WIDTH-2:0], data_in};
                  bit_cnt    <= BIT_W'(1);
                  data_clock <= 1'b1;
                  state_reg  <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (phase_end) begin
                  data_clock <= 1'b0;
                  state_reg  <= ST_LOW;
               end
            end
            ST_LOW: begin
               // Sampling on the last low cycle gives QH the longest settle before the next CP rise.
               if (phase_end) begin
                  shreg <= {shreg[WIDTH-2:0], data_in};
                  if (bit_cnt == BIT_LAST) begin
                     state_reg <= ST_DONE;
                  end else begin
                     bit_cnt    <= bit_cnt + 1'b1;
                     data_clock <= 1'b1;
                     state_reg  <= ST_HIGH;
                  end
               end
            end
            ST_DONE: begin
               data_out   <= shreg;
               data_valid <= 1'b1;
               busy       <= 1'b0;
               data_clock <= 1'b0;
               load_n     <= 1'b1;
               bit_cnt    <= '0;
               state_reg  <= ST_IDLE;
            end
            default: begin
               state_reg  <= ST_IDLE;
               busy       <= 1'b0;
               load_n     <= 1'b1;
               data_clock <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_74hc165_reader.sv
// Directed bench for control_74hc165_reader with behavioural 74HC165 chains on two configurations
// (16-bit / divide-by-4 and 8-bit / divide-by-1).
module tb_control_74hc165_reader;

   logic clk = 1'b0;
   logic s_reset = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ---------------- configuration A: WIDTH=16, CLK_DIV=4 ----------------
   logic        a_start = 1'b0;
   logic        a_data_in;
   logic        a_load_n, a_data_clock, a_data_valid, a_busy;
   logic [15:0] a_data_out;
   logic [15:0] a_par = 16'h0000;
   logic [15:0] a_chain = 16'h0000;
   int          a_rise = 0, a_load_low = 0, a_dv = 0;
   int          a_dv_cyc [4];
   logic [15:0] a_word [4];
   logic        a_busy_dv = 1'b1;

   control_74hc165_reader #(.WIDTH(16), .CLK_DIV(4)) dut_a (
      .s_clk(clk), .s_reset(s_reset), .start(a_start), .data_in(a_data_in),
      .load_n(a_load_n), .data_clock(a_data_clock), .data_out(a_data_out),
      .data_valid(a_data_valid), .busy(a_busy)
   );

   // 74HC165 chain: PL low latches parallel inputs, CP rising shifts toward QH.
   always @(posedge a_data_clock or negedge a_load_n)
      if (!a_load_n) a_chain <= a_par;
      else           a_chain <= {a_chain[14:0], 1'b0};
   assign a_data_in = a_chain[15];

   always @(posedge a_data_clock) a_rise++;
   always @(posedge clk) if (!a_load_n) a_load_low++;
   always @(negedge clk) if (a_data_valid) begin
      if (a_dv < 4) begin
         a_dv_cyc[a_dv] = cyc;
         a_word[a_dv]   = a_data_out;
      end
      a_busy_dv = a_busy;
      a_dv++;
   end

   // ---------------- configuration B: WIDTH=8, CLK_DIV=1 ----------------
   logic       b_start = 1'b0;
   logic       b_data_in;
   logic       b_load_n, b_data_clock, b_data_valid, b_busy;
   logic [7:0] b_data_out;
   logic [7:0] b_par = 8'h00;
   logic [7:0] b_chain = 8'h00;
   int         b_rise = 0, b_load_low = 0, b_dv = 0, b_dv_cyc = 0;
   logic [7:0] b_word = 8'h00;

   control_74hc165_reader #(.WIDTH(8), .CLK_DIV(1)) dut_b (
      .s_clk(clk), .s_reset(s_reset), .start(b_start), .data_in(b_data_in),
      .load_n(b_load_n), .data_clock(b_data_clock), .data_out(b_data_out),
      .data_valid(b_data_valid), .busy(b_busy)
   );

   always @(posedge b_data_clock or negedge b_load_n)
      if (!b_load_n) b_chain <= b_par;
      else           b_chain <= {b_chain[6:0], 1'b0};
   assign b_data_in = b_chain[7];

   always @(posedge b_data_clock) b_rise++;
   always @(posedge clk) if (!b_load_n) b_load_low++;
   always @(negedge clk) if (b_data_valid) begin
      b_dv_cyc = cyc;
      b_word   = b_data_out;
      b_dv++;
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Lands just after the falling edge so the negedge capture blocks have already run.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_a();
      a_rise = 0; a_load_low = 0; a_dv = 0; a_busy_dv = 1'b1;
   endtask

   int c0;

   initial begin
      // Reset and idle
      repeat (3) tick();
      s_reset = 1'b0;
      repeat (20) tick();
      check("idle_load_n", 32'(a_load_n), 32'd1);
      check("idle_data_clock", 32'(a_data_clock), 32'd0);
      check("idle_busy", 32'(a_busy), 32'd0);
      check("idle_data_valid", 32'(a_data_valid), 32'd0);
      check("idle_data_out", 32'(a_data_out), 32'h0000);

      // Single frame reading A5C3
      a_par = 16'hA5C3;
      clear_a();
      c0 = cyc;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int i = 0; i < 400 && a_dv == 0; i++) tick();
      repeat (5) tick();
      check("a5c3_dv_count", 32'(a_dv), 32'd1);
      check("a5c3_latency", 32'(a_dv_cyc[0] - c0), 32'd130);
      check("a5c3_data_out", 32'(a_word[0]), 32'hA5C3);
      check("a5c3_rises", 32'(a_rise), 32'd15);
      check("a5c3_load_low", 32'(a_load_low), 32'd4);
      check("a5c3_busy_at_dv", 32'(a_busy_dv), 32'd0);

      // start held high; inputs change after the first load
      a_par = 16'h1234;
      clear_a();
      c0 = cyc;
      a_start = 1'b1;
      repeat (20) tick();
      a_par = 16'hFFFE;
      for (int i = 0; i < 400 && a_dv < 2; i++) tick();
      a_start = 1'b0;
      repeat (5) tick();
      check("held_dv_count", 32'(a_dv), 32'd2);
      check("held_latency", 32'(a_dv_cyc[0] - c0), 32'd130);
      check("held_word0", 32'(a_word[0]), 32'h1234);
      check("held_word1", 32'(a_word[1]), 32'hFFFE);
      check("held_spacing", 32'(a_dv_cyc[1] - a_dv_cyc[0]), 32'd130);

      // start pulses while busy are dropped
      a_par = 16'h0F0F;
      repeat (5) tick();
      clear_a();
      c0 = cyc;
      for (int i = 0; i < 300; i++) begin
         a_start = (i == 0 || i == 10 || i == 60);
         tick();
      end
      a_start = 1'b0;
      check("busy_dv_count", 32'(a_dv), 32'd1);
      check("busy_latency", 32'(a_dv_cyc[0] - c0), 32'd130);
      check("busy_data_out", 32'(a_word[0]), 32'h0F0F);
      check("busy_rises", 32'(a_rise), 32'd15);

      // Reset in mid-frame
      a_par = 16'h8001;
      clear_a();
      c0 = cyc;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      while (cyc < c0 + 70) tick();
      s_reset = 1'b1;
      tick();
      check("rst_load_n", 32'(a_load_n), 32'd1);
      check("rst_data_clock", 32'(a_data_clock), 32'd0);
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_data_valid", 32'(a_data_valid), 32'd0);
      check("rst_data_out", 32'(a_data_out), 32'h0000);
      s_reset = 1'b0;
      repeat (200) tick();
      check("rst_no_dv", 32'(a_dv), 32'd0);
      check("rst_data_out_held", 32'(a_data_out), 32'h0000);

      // Narrow, undivided configuration reading 5A
      b_par = 8'h5A;
      b_rise = 0; b_load_low = 0; b_dv = 0;
      c0 = cyc;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      for (int i = 0; i < 100 && b_dv == 0; i++) tick();
      repeat (5) tick();
      check("w8_dv_count", 32'(b_dv), 32'd1);
      check("w8_latency", 32'(b_dv_cyc - c0), 32'd18);
      check("w8_data_out", 32'(b_word), 32'h5A);
      check("w8_rises", 32'(b_rise), 32'd7);
      check("w8_load_low", 32'(b_load_low), 32'd1);
      check("w8_busy_after", 32'(b_busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/control_74hc165_reader.md
Name: control_74hc165_reader

Overview:
- Reader-side counterpart of the 74HC595 shift-out driver. Controls a chain of 74HC165 parallel-in/serial-out registers (buttons, DIP switches, status lines).
- Issues a parallel-load pulse, clocks the chain, and deserialises QH into a WIDTH-bit word.
- Sits beside the 595 driver under the board top. Shares the system clock and the synchronous reset.

Parameters:
- WIDTH, 16: total chain length in bits (8 per 74HC165); must be >= 2.
- CLK_DIV, 4: system cycles per serial half-phase; must be >= 1.

Ports:
- s_clk  input  1  system clock; all logic on rising edge.
- s_reset  input  1  synchronous, active-high reset.
- start  input  1  request one read frame; sampled only when busy=0.
- data_in  input  1  serial QH from the last 74HC165 in the chain.
- load_n  output  1  PL to the chain, active-low parallel load.
- data_clock  output  1  CP to the chain; QH advances on the rising edge.
- data_out  output  WIDTH  last completed word, MSB = first bit shifted out.
- data_valid  output  1  one-cycle pulse when data_out updates.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (s_reset=1 at an edge): state IDLE, load_n=1, data_clock=0, busy=0, data_valid=0, data_out=0, counters=0. Reset mid-frame aborts the frame immediately. No partial word is published.
- All outputs are registered, with no combinational paths from input to output.
- States: IDLE, LOAD, SETTLE, HIGH, LOW, DONE.
- Phase counter div_cnt runs from 0 to CLK_DIV-1. A phase ends on the cycle where div_cnt = CLK_DIV-1. Bit counter bit_cnt runs from 0 to WIDTH-1.
- IDLE: start=1 -> LOAD, busy=1, load_n=0. start=0 -> stay in IDLE.
- LOAD: load_n=0 for CLK_DIV cycles, then -> SETTLE with load_n=1.
- SETTLE: data_clock=0 for CLK_DIV cycles. On the last cycle, sample data_in into shreg bit WIDTH-1 (MSB first), bit_cnt=1, then -> HIGH.
- HIGH: data_clock=1 for CLK_DIV cycles, then -> LOW.
- LOW: data_clock=0 for CLK_DIV cycles. On the last cycle, shift data_in into the next lower bit. If bit_cnt = WIDTH-1, go to DONE; otherwise increment bit_cnt and go to HIGH.
- Result: exactly WIDTH samples and WIDTH-1 data_clock rising edges per frame. Each sample is taken one system cycle before the following rising edge, which gives maximal QH setup.
- DONE (one cycle): data_out <= shreg, data_valid=1, busy=0, data_clock=0, load_n=1, then -> IDLE.
- Latency: start is sampled high at edge 0. load_n falls after edge 0. data_valid is high in the cycle following edge 2*CLK_DIV*WIDTH+1, i.e. 130 cycles after start for the defaults.
- Back-to-back frames: start sampled in IDLE right after DONE begins a new frame with no extra gap. start held high reads continuously, giving one frame per 2*CLK_DIV*WIDTH+2 cycles.
- start while busy=1 is ignored, not queued.
- data_out holds its value between frames and changes only together with data_valid.
- data_in is treated as synchronous to s_clk. The board top owns any synchroniser.

Decomposition:
- Shared package (board_io_pkg): state enum encoding, and constants for default WIDTH / CLK_DIV, shared with the 595 driver.
- Counter widths use $clog2 of the parameters locally.
- No sub-module is required. An optional generic phase_divider (CLK_DIV terminal-count strobe) may be split out and reused by the 595 driver.

Test Plan:
- Bench uses a behavioural 74HC165 chain model: PL low latches the parallel input, QH shows the MSB, and CP rising shifts.
- Reset, then idle 20 cycles -> load_n=1, data_clock=0, busy=0, data_valid=0, data_out=16'h0000.
- Parallel input 16'hA5C3, start pulsed 1 cycle -> load_n low 4 cycles, 15 data_clock rising edges, data_valid 1 cycle at start+130, data_out=16'hA5C3, busy low at the same edge.
- start held high with inputs 16'h1234 then 16'hFFFE (changed mid-first frame, after load) -> first word 16'h1234, second 16'hFFFE, data_valid pulses spaced 130 cycles apart.
- start pulses during busy (at +10 and +60) -> ignored. Exactly one frame occurs and one data_valid pulse.
- s_reset asserted at cycle +70 of a frame reading 16'h8001 -> next edge load_n=1, data_clock=0, busy=0, and data_out keeps its previous value (0 after reset), with no data_valid.
- Parameter sweep WIDTH=8 and CLK_DIV=1 reading 8'h5A -> data_valid at start+18, data_out=8'h5A, 7 rising edges.
